// File: rtl/vga_scroll_pkg.sv
// Shared types and constants for the VGA scroll controller.
package vga_scroll_pkg;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } run_state_e;

   localparam logic [1:0] ADDR_SPEED_X = 2'd0;
   localparam logic [1:0] ADDR_SPEED_Y = 2'd1;
   localparam logic [1:0] ADDR_CTRL    = 2'd2;
   localparam logic [1:0] ADDR_DIV     = 2'd3;

   localparam int V_LINES_DEF = 480;

endpackage

// File: rtl/vga_cfg_sync.sv
// Two-flop synchroniser for an asynchronous strobe plus rising-edge detect.
module vga_cfg_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= async_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/vga_scroll_ctrl.sv
// Frame-synchronous scroll/pattern controller with STOP/RUN/STEP sequencing.
// Optional frame divider on addr3 enabled by defining VGA_SCROLL_FRAME_DIV_EN.
module vga_scroll_ctrl
   import vga_scroll_pkg::*;
#(
   parameter int VSYNC_ACTIVE_LOW = 1,
   parameter int V_LINES          = V_LINES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [7:0] cfg_data,
   output logic       cfg_ack,
   output logic [9:0] x_offset,
   output logic [9:0] y_offset,
   output logic [1:0] pattern_sel,
   output logic [7:0] frame_cnt,
   output logic       frame_tick,
   output logic [1:0] run_state
);

   localparam logic signed [11:0] VL = 12'(V_LINES);

   logic       cfg_rise, vs_asrt, vs_prev, boundary, step_wr, adv, div_hit;
   logic [7:0] pend_sx, pend_sy, sx_nxt, sy_nxt;
   logic [1:0] pend_pat, pat_nxt;
   logic       pend_run, run_nxt;
   logic [9:0] x_sum;
   logic signed [11:0] y_sum, y_wrap;
   run_state_e state, state_nxt;

   vga_cfg_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (cfg_we),
      .rise     (cfg_rise)
   );

   assign vs_asrt  = (VSYNC_ACTIVE_LOW != 0) ? ~vsync : vsync;
   assign boundary = vs_asrt & ~vs_prev;

   // Speeds are only consumed at boundaries, so the pending value including a
   // same-cycle write is exactly the committed value; no separate active copy.
   always_comb begin
      sx_nxt  = pend_sx;
      sy_nxt  = pend_sy;
      pat_nxt = pend_pat;
      run_nxt = pend_run;
      step_wr = 1'b0;
      if (cfg_rise) begin
         case (cfg_addr)
            ADDR_SPEED_X: sx_nxt = cfg_data;
            ADDR_SPEED_Y: sy_nxt = cfg_data;
            ADDR_CTRL: begin
               pat_nxt = cfg_data[1:0];
               run_nxt = cfg_data[2];
               step_wr = cfg_data[3];
            end
            default: ;
         endcase
      end
   end

`ifdef VGA_SCROLL_FRAME_DIV_EN
   logic [7:0] pend_div, div_nxt, div_cnt;

   always_comb begin
      div_nxt = pend_div;
      if (cfg_rise && cfg_addr == ADDR_DIV) div_nxt = cfg_data;
   end

   assign div_hit = (div_cnt == div_nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_div <= 8'd0;
         div_cnt  <= 8'd0;
      end else begin
         pend_div <= div_nxt;
         if (boundary) div_cnt <= (state_nxt == ST_RUN && !div_hit) ? div_cnt + 8'd1 : 8'd0;
         else if (state != ST_RUN) div_cnt <= 8'd0;
      end
   end
`else
   assign div_hit = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_STOP: begin
            if (boundary && run_nxt) state_nxt = ST_RUN;
            else if (step_wr)        state_nxt = ST_STEP;
         end
         ST_RUN:  if (boundary && !run_nxt) state_nxt = ST_STOP;
         ST_STEP: if (boundary)             state_nxt = ST_STOP;
         default: state_nxt = ST_STOP;
      endcase
      // A boundary that commits run=1 moves offsets even when leaving STOP.
      adv = boundary && ((state == ST_STEP) || (run_nxt && div_hit));
   end

   assign x_sum  = x_offset + {{2{sx_nxt[7]}}, sx_nxt};
   assign y_sum  = $signed({2'b00, y_offset}) + $signed({{4{sy_nxt[7]}}, sy_nxt});
   assign y_wrap = (y_sum < 0) ? y_sum + VL : (y_sum >= VL) ? y_sum - VL : y_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_STOP;
         vs_prev     <= 1'b1;
         pend_sx     <= 8'd0;
         pend_sy     <= 8'd0;
         pend_pat    <= 2'd0;
         pend_run    <= 1'b0;
         pattern_sel <= 2'd0;
         x_offset    <= 10'd0;
         y_offset    <= 10'd0;
         frame_cnt   <= 8'd0;
         frame_tick  <= 1'b0;
         cfg_ack     <= 1'b0;
      end else begin
         state      <= state_nxt;
         vs_prev    <= vs_asrt;
         pend_sx    <= sx_nxt;
         pend_sy    <= sy_nxt;
         pend_pat   <= pat_nxt;
         pend_run   <= run_nxt;
         frame_tick <= boundary;
         cfg_ack    <= cfg_rise;
         if (boundary) begin
            pattern_sel <= pat_nxt;
            frame_cnt   <= frame_cnt + 8'd1;
         end
         if (adv) begin
            x_offset <= x_sum;
            y_offset <= y_wrap[9:0];
         end
      end
   end

   assign run_state = state;

   logic unused_ok;
   assign unused_ok = ^{cfg_data[7:4]};

endmodule

// File: tb/tb_vga_scroll_ctrl.sv
// Directed self-checking bench for vga_scroll_ctrl (active-low vsync, 480 lines).
module tb_vga_scroll_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vsync = 1'b1;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = 2'd0;
   logic [7:0] cfg_data = 8'd0;
   logic       cfg_ack, frame_tick;
   logic [9:0] x_offset, y_offset;
   logic [1:0] pattern_sel, run_state;
   logic [7:0] frame_cnt;

   int n_chk = 0;
   int n_pass = 0;
   int ack_cnt = 0;
   int tick_cnt = 0;

   vga_scroll_ctrl #(.VSYNC_ACTIVE_LOW(1), .V_LINES(480)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vsync       (vsync),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .cfg_ack     (cfg_ack),
      .x_offset    (x_offset),
      .y_offset    (y_offset),
      .pattern_sel (pattern_sel),
      .frame_cnt   (frame_cnt),
      .frame_tick  (frame_tick),
      .run_state   (run_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cfg_ack)    ack_cnt  <= ack_cnt + 1;
      if (frame_tick) tick_cnt <= tick_cnt + 1;
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; vsync = 1'b1; cfg_we = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cfg_addr = a; cfg_data = d;
      repeat (3) @(negedge clk);
      cfg_we = 1'b1;
      repeat (4) @(negedge clk);
      cfg_we = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic frame();
      @(negedge clk);
      vsync = 1'b0;
      repeat (3) @(negedge clk);
      vsync = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      int t0;
      rst_n = 1'b0; vsync = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if ({x_offset, y_offset} !== 20'd0) $display("FAIL reset_offsets x=%0d y=%0d exp 0 0", x_offset, y_offset); else n_pass++;
      n_chk++; if ({pattern_sel, run_state, frame_cnt, frame_tick, cfg_ack} !== 14'd0)
         $display("FAIL reset_ctrl pat=%0d st=%0d fc=%0d tick=%b ack=%b exp all 0", pattern_sel, run_state, frame_cnt, frame_tick, cfg_ack);
      else n_pass++;
      t0 = tick_cnt;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      vsync = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if (tick_cnt - t0 !== 0 || frame_cnt !== 8'd0) $display("FAIL reset_vsync_release ticks=%0d fc=%0d exp 0 0", tick_cnt - t0, frame_cnt); else n_pass++;
   endtask

   task automatic test_run_x();
      int a0;
      int exp_x;
      do_reset();
      a0 = ack_cnt;
      cfg_write(2'd0, 8'h05);
      cfg_write(2'd2, 8'h04);
      n_chk++; if (ack_cnt - a0 !== 2) $display("FAIL run_acks got=%0d exp=2", ack_cnt - a0); else n_pass++;
      n_chk++; if (run_state !== 2'd0 || x_offset !== 10'd0) $display("FAIL run_pre st=%0d x=%0d exp 0 0", run_state, x_offset); else n_pass++;
      for (int i = 1; i <= 3; i++) begin
         frame();
         exp_x = 5 * i;
         n_chk++; if (x_offset !== 10'(exp_x) || run_state !== 2'd1) $display("FAIL run_x%0d x=%0d st=%0d exp %0d 1", i, x_offset, run_state, exp_x); else n_pass++;
      end
      n_chk++; if (frame_cnt !== 8'd3 || y_offset !== 10'd0) $display("FAIL run_fc fc=%0d y=%0d exp 3 0", frame_cnt, y_offset); else n_pass++;
   endtask

   task automatic test_y_neg();
      do_reset();
      cfg_write(2'd1, 8'hF6);
      cfg_write(2'd2, 8'h04);
      frame();
      n_chk++; if (y_offset !== 10'd470) $display("FAIL yneg_1 y=%0d exp=470", y_offset); else n_pass++;
      frame();
      n_chk++; if (y_offset !== 10'd460) $display("FAIL yneg_2 y=%0d exp=460", y_offset); else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset();
      cfg_write(2'd0, 8'h7D);
      cfg_write(2'd1, 8'hF6);
      cfg_write(2'd2, 8'h04);
      frame();
      cfg_write(2'd1, 8'h00);
      repeat (7) frame();
      n_chk++; if (x_offset !== 10'd1000 || y_offset !== 10'd470) $display("FAIL wrap_pre x=%0d y=%0d exp 1000 470", x_offset, y_offset); else n_pass++;
      cfg_write(2'd0, 8'h7F);
      cfg_write(2'd1, 8'h14);
      frame();
      n_chk++; if (x_offset !== 10'd103) $display("FAIL wrap_x x=%0d exp=103", x_offset); else n_pass++;
      n_chk++; if (y_offset !== 10'd10) $display("FAIL wrap_y y=%0d exp=10", y_offset); else n_pass++;
   endtask

   task automatic test_step();
      do_reset();
      cfg_write(2'd0, 8'h03);
      cfg_write(2'd1, 8'h02);
      cfg_write(2'd2, 8'h08);
      n_chk++; if (run_state !== 2'd2 || x_offset !== 10'd0) $display("FAIL step_enter st=%0d x=%0d exp 2 0", run_state, x_offset); else n_pass++;
      frame();
      n_chk++; if (x_offset !== 10'd3 || y_offset !== 10'd2 || run_state !== 2'd0) $display("FAIL step_adv x=%0d y=%0d st=%0d exp 3 2 0", x_offset, y_offset, run_state); else n_pass++;
      frame();
      n_chk++; if (x_offset !== 10'd3 || y_offset !== 10'd2) $display("FAIL step_hold x=%0d y=%0d exp 3 2", x_offset, y_offset); else n_pass++;
      cfg_write(2'd2, 8'h04);
      frame();
      n_chk++; if (x_offset !== 10'd6 || run_state !== 2'd1) $display("FAIL step_run x=%0d st=%0d exp 6 1", x_offset, run_state); else n_pass++;
      cfg_write(2'd2, 8'h0C);
      n_chk++; if (run_state !== 2'd1) $display("FAIL step_ign_run st=%0d exp=1", run_state); else n_pass++;
      cfg_write(2'd2, 8'h00);
      frame();
      n_chk++; if (run_state !== 2'd0 || x_offset !== 10'd6 || y_offset !== 10'd4) $display("FAIL run_stop st=%0d x=%0d y=%0d exp 0 6 4", run_state, x_offset, y_offset); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int a0;
      do_reset();
      a0 = ack_cnt;
      @(negedge clk);
      cfg_addr = 2'd2; cfg_data = 8'h02;
      repeat (3) @(negedge clk);
      cfg_we = 1'b1;
      repeat (2) @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
      n_chk++; if (pattern_sel !== 2'd2 || frame_tick !== 1'b1) $display("FAIL same_cycle pat=%0d tick=%b exp 2 1", pattern_sel, frame_tick); else n_pass++;
      repeat (2) @(negedge clk);
      vsync = 1'b1; cfg_we = 1'b0;
      repeat (4) @(negedge clk);
      n_chk++; if (ack_cnt - a0 !== 1) $display("FAIL same_cycle_ack got=%0d exp=1", ack_cnt - a0); else n_pass++;
      n_chk++; if (run_state !== 2'd0 || frame_cnt !== 8'd1) $display("FAIL same_cycle_st st=%0d fc=%0d exp 0 1", run_state, frame_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid_write();
      int a0;
      do_reset();
      a0 = ack_cnt;
      @(negedge clk);
      cfg_addr = 2'd2; cfg_data = 8'h07;
      repeat (3) @(negedge clk);
      cfg_we = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      cfg_we = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_chk++; if (ack_cnt - a0 !== 0 || pattern_sel !== 2'd0) $display("FAIL mid_write ack=%0d pat=%0d exp 0 0", ack_cnt - a0, pattern_sel); else n_pass++;
      frame();
      n_chk++; if (run_state !== 2'd0 || pattern_sel !== 2'd0) $display("FAIL mid_write_discard st=%0d pat=%0d exp 0 0", run_state, pattern_sel); else n_pass++;
   endtask

`ifdef VGA_SCROLL_FRAME_DIV_EN
   task automatic test_frame_div();
      int exp_x [6] = '{0, 0, 1, 1, 1, 2};
      int t0;
      do_reset();
      cfg_write(2'd0, 8'h01);
      cfg_write(2'd3, 8'h02);
      cfg_write(2'd2, 8'h04);
      for (int i = 0; i < 6; i++) begin
         frame();
         n_chk++; if (x_offset !== 10'(exp_x[i])) $display("FAIL div_b%0d x=%0d exp=%0d", i + 1, x_offset, exp_x[i]); else n_pass++;
      end
      @(negedge clk);
      vsync = 1'b0; rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if ({x_offset, y_offset, pattern_sel, run_state, frame_cnt, frame_tick, cfg_ack} !== 34'd0)
         $display("FAIL div_reset x=%0d st=%0d fc=%0d exp 0 0 0", x_offset, run_state, frame_cnt);
      else n_pass++;
      t0 = tick_cnt;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      vsync = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if (tick_cnt - t0 !== 0) $display("FAIL div_release ticks=%0d exp=0", tick_cnt - t0); else n_pass++;
   endtask
`else
   task automatic test_addr3_ignored();
      int a0;
      do_reset();
      a0 = ack_cnt;
      cfg_write(2'd0, 8'h01);
      cfg_write(2'd3, 8'h02);
      cfg_write(2'd2, 8'h04);
      n_chk++; if (ack_cnt - a0 !== 3) $display("FAIL addr3_ack got=%0d exp=3", ack_cnt - a0); else n_pass++;
      repeat (3) frame();
      n_chk++; if (x_offset !== 10'd3) $display("FAIL addr3_nodiv x=%0d exp=3", x_offset); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_run_x();
      test_y_neg();
      test_wrap();
      test_step();
      test_back_to_back();
      test_reset_mid_write();
`ifdef VGA_SCROLL_FRAME_DIV_EN
      test_frame_div();
`else
      test_addr3_ignored();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_scroll_ctrl.md
VGA_SCROLL_CTRL -- requirements
Module: vga_scroll_ctrl

Interface
REQ-001 SHALL have parameter VSYNC_ACTIVE_LOW, default 1, meaning vsync asserts low (1) or high (0).
REQ-002 SHALL have parameter V_LINES, default 480, meaning modulus for y_offset wrap.
REQ-003 SHALL have port clk, input, 1, meaning pixel clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port vsync, input, 1, meaning vertical sync from the timing generator, synchronous to clk.
REQ-006 SHALL have port cfg_we, input, 1, meaning asynchronous write strobe from a pin.
REQ-007 SHALL have port cfg_addr, input, 2, meaning register address, stable from 3 clk before to 3 clk after the cfg_we rise.
REQ-008 SHALL have port cfg_data, input, 8, meaning write data, with the same stability rule as cfg_addr.
REQ-009 SHALL have port cfg_ack, output, 1, meaning one-cycle pulse per accepted write.
REQ-010 SHALL have port x_offset, output, 10, meaning horizontal scroll added to pix_x by the pattern datapath.
REQ-011 SHALL have port y_offset, output, 10, meaning vertical scroll, range 0..V_LINES-1.
REQ-012 SHALL have port pattern_sel, output, 2, meaning active pattern for the datapath.
REQ-013 SHALL have port frame_cnt, output, 8, meaning free-running frame counter.
REQ-014 SHALL have port frame_tick, output, 1, meaning one-cycle pulse per frame boundary.
REQ-015 SHALL have port run_state, output, 2, meaning current state encoding: STOP=0, RUN=1, STEP=2.

Function
REQ-016 SHALL synchronise cfg_we through 2 flops and detect the rising edge; on detection it SHALL sample cfg_addr/cfg_data and pulse cfg_ack the following cycle.
REQ-017 SHALL decode writes as: addr0 pending speed_x, signed 8; addr1 pending speed_y, signed 8; addr2 pending ctrl, where [1:0] is pattern, [2] is run and [3] is step; addr3 as per REQ-030/031.
REQ-018 SHALL define the frame boundary as the clk edge where vsync is sampled asserted while the registered previous sample was deasserted.
REQ-019 SHALL, at each boundary, commit the pending speed_x, speed_y, pattern and run values to the active registers; a write detected in the same cycle SHALL be included in the commit.
REQ-020 SHALL always increment frame_cnt by 1 modulo 256 at each boundary and raise frame_tick for the one cycle after it.
REQ-021 SHALL implement the state machine as follows: from STOP, go to RUN at a boundary committing run=1; go to STEP when a step write is detected while in STOP; from STEP, go to STOP at the next boundary after advancing once; from RUN, go to STOP at a boundary committing run=0.
REQ-022 SHALL treat the step bit as self-clearing and ignore it in RUN or STEP.
REQ-023 SHALL advance, at each boundary in RUN or STEP, x_offset to (x_offset + sext(speed_x)) mod 1024, using the speeds committed at that same boundary.
REQ-024 SHALL advance, at each boundary in RUN or STEP, y_offset to y_offset + sext(speed_y); add V_LINES if the result is below 0; subtract V_LINES if the result is at or above V_LINES.
REQ-025 SHALL hold both offsets at every boundary while in STOP.
REQ-026 SHALL make pattern_sel follow the committed pattern, changing only at boundaries.

Reset
REQ-027 SHALL, while rst_n is low, set x_offset=0, y_offset=0, pattern_sel=0, frame_cnt=0, frame_tick=0, cfg_ack=0, run_state=STOP, all pending/active registers=0 and sync flops=0.
REQ-028 SHALL reset the registered previous vsync sample to the asserted level, so that vsync asserted at reset release produces no boundary.
REQ-029 SHALL return to the full reset state immediately on reset mid-frame or mid-write, discarding the pending write and producing no cfg_ack.

Configuration
REQ-030 SHALL, with VGA_SCROLL_FRAME_DIV_EN defined, treat addr3 as pending frame divider N (8-bit, committed at boundaries) and advance offsets (REQ-023/024) only on every (N+1)-th boundary in RUN; STEP SHALL always advance at the next boundary; the divider counter SHALL clear on reset and on leaving RUN.
REQ-031 SHALL, with VGA_SCROLL_FRAME_DIV_EN undefined, acknowledge addr3 writes but ignore their data, and advance offsets every boundary in RUN.

Structure
REQ-032 SHALL place the state enum, the register address constants and the default V_LINES in package vga_scroll_pkg.
REQ-033 SHALL implement the 2-flop synchroniser plus rising-edge detector as sub-module vga_cfg_sync.

Verification
REQ-034 SHALL cover: write addr0=0x05 and addr2=0x04, then 3 boundaries -> x_offset 0,5,10,15 at successive boundaries; run_state=RUN from the first boundary.
REQ-035 SHALL cover: speed_y=0xF6 (-10) from y_offset=0 in RUN -> y_offset 470, then 460.
REQ-036 SHALL cover: speed_x=0x7F with x_offset=1000 -> x_offset 103 (wrap); speed_y=+20 at y=470 -> y_offset 10.
REQ-037 SHALL cover: in STOP, write addr2=0x08 -> run_state=STEP; next boundary offsets advance once, run_state=STOP; the following boundary leaves offsets unchanged.
REQ-038 SHALL cover: a cfg_we edge detected on the boundary cycle writing pattern=2 -> pattern_sel=2 after that same boundary; cfg_ack pulses exactly once.
REQ-039 SHALL cover: with VGA_SCROLL_FRAME_DIV_EN, N=2 in RUN with speed_x=1 -> x_offset increments every 3rd boundary; reset asserted mid-run -> all outputs 0, and vsync asserted at release produces no frame_tick.
